// File: rtl/alu_issue_if.sv
// alu_issue_if: decode handshake, ALU start/done and operand/result steering bundle
interface alu_issue_if #(parameter int WORD_SIZE = 8);
  logic                 instr_valid;
  logic                 instr_ready;
  logic [3:0]           instr_opcode;
  logic [2:0]           instr_dst;
  logic [2:0]           instr_src_a;
  logic [3:0]           instr_src_b;
  logic [WORD_SIZE-1:0] instr_imm8;
  logic                 mux_a_en;
  logic [2:0]           mux_a_sel;
  logic                 mux_b_en;
  logic [3:0]           mux_b_sel;
  logic [WORD_SIZE-1:0] imm_out;
  logic [3:0]           alu_op;
  logic                 alu_start;
  logic                 alu_done;
  logic                 wb_en;
  logic [2:0]           wb_sel;
  logic                 done;
  logic                 err_illegal;
  logic                 err_timeout;
  logic                 err_clear;
  logic [15:0]          retired_count;
  modport master (
    output instr_valid, instr_opcode, instr_dst, instr_src_a, instr_src_b, instr_imm8, alu_done, err_clear,
    input  instr_ready, mux_a_en, mux_a_sel, mux_b_en, mux_b_sel, imm_out, alu_op, alu_start, wb_en, wb_sel,
           done, err_illegal, err_timeout, retired_count
  );
  modport slave (
    input  instr_valid, instr_opcode, instr_dst, instr_src_a, instr_src_b, instr_imm8, alu_done, err_clear,
    output instr_ready, mux_a_en, mux_a_sel, mux_b_en, mux_b_sel, imm_out, alu_op, alu_start, wb_en, wb_sel,
           done, err_illegal, err_timeout, retired_count
  );
endinterface

// File: rtl/alu_issue_sequencer.sv
// alu_issue_sequencer: multi-cycle issue controller steering operands, ALU handshake and writeback
module alu_issue_sequencer #(
  parameter int          WORD_SIZE      = 8,
  parameter int          TIMEOUT_CYCLES = 16,
  parameter logic [15:0] NOWB_MASK      = 16'h8000,
  parameter logic [3:0]  NOP_OPCODE     = 4'hF
) (
  input logic        clk,
  input logic        rst_n,
  alu_issue_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, SETUP, EXEC, WB, RETIRE} state_t;
  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic          w_accept, w_illegal, w_timeout;
  assign w_accept  = bus.instr_ready && bus.instr_valid;
  assign w_illegal = w_accept && bus.instr_src_b > 4'd8;
  assign w_timeout = r_state == EXEC && !bus.alu_done && r_cnt == CW'(TIMEOUT_CYCLES - 1);
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  // next state: alu_done is only honoured in EXEC and beats a simultaneous timeout
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = (w_illegal || bus.instr_opcode == NOP_OPCODE) ? RETIRE : SETUP;
      SETUP:   w_next = EXEC;
      EXEC:    if (bus.alu_done) w_next = NOWB_MASK[bus.alu_op] ? RETIRE : WB;
               else if (w_timeout) w_next = RETIRE;
      WB:      w_next = RETIRE;
      RETIRE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // EXEC cycle counter, cleared whenever the FSM is outside EXEC
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else r_cnt <= (r_state == EXEC) ? r_cnt + CW'(1) : '0;
  // strobes registered from the next state so they line up exactly with the state they belong to
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.instr_ready   <= 1'b0;
      bus.mux_a_en      <= 1'b0;
      bus.mux_b_en      <= 1'b0;
      bus.alu_start     <= 1'b0;
      bus.wb_en         <= 1'b0;
      bus.done          <= 1'b0;
      bus.retired_count <= '0;
    end else begin
      bus.instr_ready <= w_next == IDLE;
      bus.mux_a_en    <= w_next inside {SETUP, EXEC, WB};
      bus.mux_b_en    <= w_next inside {SETUP, EXEC, WB};
      bus.alu_start   <= w_next == SETUP;
      bus.wb_en       <= w_next == WB;
      bus.done        <= w_next == RETIRE;
      if (w_next == RETIRE) bus.retired_count <= bus.retired_count + 16'd1;
    end
  // selects captured only on acceptance, so they stay frozen while any enable is high
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.mux_a_sel <= '0;
      bus.mux_b_sel <= '0;
      bus.wb_sel    <= '0;
      bus.alu_op    <= '0;
      bus.imm_out   <= '0;
    end else if (w_accept) begin
      bus.mux_a_sel <= bus.instr_src_a;
      bus.mux_b_sel <= bus.instr_src_b;
      bus.wb_sel    <= bus.instr_dst;
      bus.alu_op    <= bus.instr_opcode;
      bus.imm_out   <= bus.instr_imm8[WORD_SIZE-1:0];
    end
  // sticky error flags; a set in the same cycle as err_clear wins
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.err_illegal <= 1'b0;
      bus.err_timeout <= 1'b0;
    end else begin
      bus.err_illegal <= w_illegal || (bus.err_illegal && !bus.err_clear);
      bus.err_timeout <= w_timeout || (bus.err_timeout && !bus.err_clear);
    end
endmodule

// File: tb/tb_alu_issue_sequencer.sv
// tb_alu_issue_sequencer: randomized transaction-level check of the issue sequencer against a timing model
module tb_alu_issue_sequencer;
  localparam logic [15:0] MASK = 16'h8030;
  localparam int          TMO  = 16;
  logic clk = 0;
  logic rst_n = 1;
  int n_chk = 0;
  int n_err = 0;
  logic m_ill = 0;
  logic m_to = 0;
  logic [15:0] m_cnt = 0;
  alu_issue_if #(.WORD_SIZE(8)) bus ();
  alu_issue_sequencer #(.WORD_SIZE(8), .TIMEOUT_CYCLES(TMO), .NOWB_MASK(MASK), .NOP_OPCODE(4'hF))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // one instruction end to end; k = EXEC cycle that raises alu_done (0 = never)
  task automatic issue(input logic [3:0] op, input logic [2:0] dst, input logic [2:0] sa,
                       input logic [3:0] sb, input logic [7:0] imm, input int k, input bit clr);
    bit alu, wb;
    int dk, e_done, e_wb, e_en, t, st_t, wb_t, dn_t, starts, wbs, dns, ens, n;
    logic [2:0] wsel;
    alu = sb <= 4'd8 && op != 4'hF;
    dk = (alu && k >= 1 && k <= TMO) ? k : 0;
    wb = alu && dk != 0 && !MASK[op];
    e_done = !alu ? 1 : (dk == 0 ? TMO + 2 : dk + 2 + int'(wb));
    e_wb = wb ? dk + 2 : -1;
    e_en = alu ? 1 + (dk == 0 ? TMO : dk) + int'(wb) : 0;
    n = 0;
    while (!bus.instr_ready && n < 50) begin @(negedge clk); n++; end
    chk("ready_wait", bus.instr_ready, 1);
    bus.instr_valid = 1; bus.instr_opcode = op; bus.instr_dst = dst;
    bus.instr_src_a = sa; bus.instr_src_b = sb; bus.instr_imm8 = imm; bus.err_clear = clr;
    t = 0; st_t = -1; wb_t = -1; dn_t = -1; starts = 0; wbs = 0; dns = 0; ens = 0; wsel = 0;
    while (t < 40 && (dn_t < 0 || t <= dn_t)) begin
      @(negedge clk); t++;
      bus.instr_valid = 0; bus.err_clear = 0;
      bus.instr_opcode = 4'($urandom); bus.instr_dst = 3'($urandom);
      bus.instr_src_a = 3'($urandom); bus.instr_src_b = 4'($urandom); bus.instr_imm8 = 8'($urandom);
      if (bus.alu_start) begin starts++; st_t = t; end
      if (bus.wb_en) begin wbs++; wb_t = t; wsel = bus.wb_sel; end
      if (bus.mux_a_en && bus.mux_b_en) ens++;
      if (bus.done) begin dns++; dn_t = t; end
      bus.alu_done = (t >= 2 && t - 1 == k) || (t == 1 && k != 1 && $urandom_range(1) == 1);
    end
    bus.alu_done = 0;
    m_ill = sb > 4'd8 ? 1'b1 : (clr ? 1'b0 : m_ill);
    m_to = (alu && dk == 0) ? 1'b1 : (clr ? 1'b0 : m_to);
    m_cnt++;
    chk("done_t", dn_t, e_done);
    chk("done_n", dns, 1);
    chk("start_n", starts, int'(alu));
    chk("start_t", st_t, alu ? 1 : -1);
    chk("wb_n", wbs, int'(wb));
    chk("wb_t", wb_t, e_wb);
    if (wb) chk("wb_sel", wsel, dst);
    chk("en_cycles", ens, e_en);
    chk("ready_after", bus.instr_ready, 1);
    chk("mux_a_sel", bus.mux_a_sel, sa);
    chk("mux_b_sel", bus.mux_b_sel, sb);
    chk("imm_out", bus.imm_out, imm);
    chk("alu_op", bus.alu_op, op);
    chk("err_illegal", bus.err_illegal, m_ill);
    chk("err_timeout", bus.err_timeout, m_to);
    chk("retired", bus.retired_count, m_cnt);
  endtask
  task automatic clear_pulse();
    bus.err_clear = 1;
    @(negedge clk);
    bus.err_clear = 0;
    m_ill = 0; m_to = 0;
    chk("clr_illegal", bus.err_illegal, m_ill);
    chk("clr_timeout", bus.err_timeout, m_to);
  endtask
  initial begin
    int dn;
    bus.instr_valid = 0; bus.instr_opcode = 0; bus.instr_dst = 0; bus.instr_src_a = 0;
    bus.instr_src_b = 0; bus.instr_imm8 = 0; bus.alu_done = 0; bus.err_clear = 0;
    #2 rst_n = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.instr_ready, 0);
    chk("rst_strobes", {bus.mux_a_en, bus.mux_b_en, bus.alu_start, bus.wb_en, bus.done, bus.err_illegal, bus.err_timeout}, 0);
    chk("rst_count", bus.retired_count, 0);
    rst_n = 1;
    @(negedge clk);
    chk("ready_release", bus.instr_ready, 1);
    issue(4'd2, 3'd5, 3'd3, 4'd8, 8'hA5, 1, 0);
    issue(4'd4, 3'd1, 3'd2, 4'd6, 8'h3C, 3, 0);
    issue(4'd1, 3'd2, 3'd4, 4'd9, 8'h11, 1, 0);
    clear_pulse();
    issue(4'd3, 3'd7, 3'd0, 4'd12, 8'h22, 2, 1);
    issue(4'd6, 3'd4, 3'd1, 4'd0, 8'h5A, 0, 0);
    issue(4'd7, 3'd6, 3'd5, 4'd7, 8'hC3, TMO, 1);
    issue(4'd5, 3'd3, 3'd6, 4'd8, 8'h0F, TMO, 0);
    // reset while the instruction sits in EXEC
    bus.instr_valid = 1; bus.instr_opcode = 4'd1; bus.instr_src_b = 4'd2;
    @(negedge clk); bus.instr_valid = 0;
    repeat (2) @(negedge clk);
    rst_n = 0;
    #1;
    chk("midrst_strobes", {bus.instr_ready, bus.mux_a_en, bus.mux_b_en, bus.alu_start, bus.wb_en, bus.done, bus.err_illegal, bus.err_timeout}, 0);
    chk("midrst_count", bus.retired_count, 0);
    chk("midrst_sels", {bus.mux_a_sel, bus.mux_b_sel, bus.wb_sel, bus.alu_op, bus.imm_out}, 0);
    m_cnt = 0; m_ill = 0; m_to = 0;
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    chk("midrst_ready", bus.instr_ready, 1);
    dn = 0;
    repeat (4) begin @(negedge clk); dn += int'(bus.done); end
    chk("midrst_nodone", dn, 0);
    // back-to-back NOPs with valid held high
    bus.instr_valid = 1; bus.instr_opcode = 4'hF; bus.instr_src_b = 4'd0;
    dn = 0;
    for (int t = 1; t <= 8; t++) begin
      @(negedge clk);
      if (t == 8) bus.instr_valid = 0;
      chk("nop_pattern", bus.done, t % 2);
      dn += int'(bus.done);
    end
    m_cnt += 16'(dn);
    chk("nop_count", bus.retired_count, m_cnt);
    // counter wrap
    force bus.retired_count = 16'hFFFF;
    #1 release bus.retired_count;
    m_cnt = 16'hFFFF;
    issue(4'hF, 3'd0, 3'd0, 4'd1, 8'h00, 0, 0);
    for (int i = 0; i < 60; i++) begin
      logic [3:0] sb;
      sb = ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(8));
      issue(4'($urandom_range(15)), 3'($urandom), 3'($urandom), sb, 8'($urandom),
            ($urandom_range(4) == 0) ? 0 : $urandom_range(1, TMO), $urandom_range(4) == 0);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/alu_issue_sequencer.md
Name: alu_issue_sequencer

Overview:
- Multi-cycle issue controller for the ALU datapath. Accepts one decoded instruction per valid/ready handshake and drives the register-to-ALU-A mux, the register/immediate-to-ALU-B mux, the ALU start/done handshake, and the ALU-output-to-register writeback demux.
- Sits between instruction decode and the ALU operand/result steering logic.
- Detects illegal B-operand selects and ALU timeouts, and counts retired instructions.

Parameters:
- WORD_SIZE, 8: datapath width; sets the immediate width.
- TIMEOUT_CYCLES, 16: maximum EXEC cycles to wait for alu_done (must be ≥1).
- NOWB_MASK, 16'h8000: bit n set means opcode n does not write back (e.g. compare). Bit 15 also covers NOP.
- NOP_OPCODE, 4'hF: opcode retired without touching the ALU.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- instr_valid  in  1  instruction offered
- instr_ready  out  1  sequencer can accept
- instr_opcode  in  4  ALU operation
- instr_dst  in  3  destination register 0-7
- instr_src_a  in  3  A operand register 0-7
- instr_src_b  in  4  B operand: 0-7 register, 8 immediate, 9-15 illegal
- instr_imm8  in  WORD_SIZE  immediate value
- mux_a_en  out  1  A-mux enable
- mux_a_sel  out  3  A-mux select
- mux_b_en  out  1  B-mux enable
- mux_b_sel  out  4  B-mux select
- imm_out  out  WORD_SIZE  captured immediate, fed to the B-mux immediate input
- alu_op  out  4  captured opcode
- alu_start  out  1  one-cycle start pulse
- alu_done  in  1  ALU result valid
- wb_en  out  1  writeback demux enable
- wb_sel  out  3  writeback demux select
- done  out  1  one-cycle retire pulse
- err_illegal  out  1  sticky: illegal src_b seen
- err_timeout  out  1  sticky: ALU timeout
- err_clear  in  1  synchronous clear of both sticky flags
- retired_count  out  16  retired instructions, wraps at 16'hFFFF→0

Behaviour:
- **Reset (rst_n low):** all registered outputs go to 0 immediately, the FSM goes to IDLE, and the timeout counter clears. Reset mid-instruction abandons that instruction: no done pulse, no writeback.
- **Outputs:** all outputs are registered. instr_ready is 0 in reset and is 1 exactly while the FSM is in IDLE.
- **FSM states:** IDLE, SETUP, EXEC, WB, RETIRE.
- **IDLE:**
  - On instr_valid && instr_ready, capture opcode, dst, src_a, src_b and imm into the select, alu_op and imm_out registers.
  - If src_b > 8: set err_illegal and go to RETIRE. No ALU access.
  - Else if opcode == NOP_OPCODE: go to RETIRE.
  - Else: go to SETUP.
- **SETUP:** mux_a_en = mux_b_en = 1 and alu_start = 1 for this one cycle. Clear the timeout counter. Go to EXEC.
- **EXEC:**
  - mux enables stay high and the counter increments each cycle.
  - On alu_done: go to WB if NOWB_MASK[opcode] == 0, else go to RETIRE.
  - If the counter reaches TIMEOUT_CYCLES without alu_done: set err_timeout and go to RETIRE with no writeback.
  - If alu_done arrives in the same cycle the limit is reached, alu_done wins.
- **WB:** mux enables stay high and wb_en = 1 for exactly one cycle, with wb_sel = captured dst. Go to RETIRE.
- **RETIRE:**
  - done = 1 for one cycle and all enables are 0.
  - retired_count increments, including for illegal, NOP and timed-out instructions.
  - Go to IDLE.
- **Selects:** mux_a_sel, mux_b_sel, wb_sel, alu_op and imm_out hold their captured values until the next acceptance. They are never changed while any enable is high.
- **Latency:** with alu_done in the first EXEC cycle, acceptance edge at T0 gives SETUP at T1, EXEC at T2, WB at T3, RETIRE (done) at T4, and instr_ready again at T5. NOP and illegal instructions give done at T1 and ready at T2.
- **alu_done outside EXEC:** ignored.
- **err_clear:** clears both sticky flags. If a set and err_clear occur in the same cycle, the set wins.
- **instr_valid handling:** instr_valid may drop without acceptance, and inputs are only sampled on acceptance.

Test Plan:
1. Reset, then issue opcode 2, dst 5, src_a 3, src_b 8, imm 8'hA5; alu_done on the first EXEC cycle -> mux_a_sel=3, mux_b_sel=8, imm_out=8'hA5, alu_start pulses at T1, wb_en with wb_sel=5 at T3, done at T4, retired_count=1.
2. Opcode with NOWB_MASK bit set, src_b 6 -> wb_en never asserts; done follows the alu_done cycle by one cycle.
3. src_b 9 -> err_illegal=1, no alu_start, done at T1. Then err_clear pulse -> err_illegal=0. Also apply a simultaneous illegal set and err_clear -> err_illegal stays 1.
4. alu_done withheld -> after 16 EXEC cycles err_timeout=1, no wb_en, done once. Separately, alu_done exactly on cycle 16 -> normal writeback, err_timeout=0.
5. Assert rst_n low during EXEC -> all outputs 0 immediately, no done, instr_ready=1 on the first edge after release. Back-to-back valid NOPs -> done every second cycle.
6. Preload 16'hFFFF retirements (or force the counter) and retire one more -> retired_count=0.
